// File: rtl/seq_digit_buffer.sv
// Keypad digit shift buffer for the 7-seg display: edge-detected entry and backspace,
// fill tracking, and a pattern detector with a saturating hit counter.
module seq_digit_buffer #(
  parameter int                     DIGITS  = 8,
  parameter int                     DW      = 4,
  parameter int                     PAT_LEN = 4,
  parameter logic [PAT_LEN*DW-1:0]  PATTERN = 16'h230B,
  localparam int                    CW      = $clog2(DIGITS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 bs,
  input  logic [DW-1:0]        dat,
  output logic [DIGITS*DW-1:0] disp_seq,
  output logic [DIGITS-1:0]    disp_off,
  output logic [CW-1:0]        count,
  output logic                 full,
  output logic                 match,
  output logic [7:0]           match_cnt
);

  logic                 ce_d;
  logic                 bs_d;
  logic                 ce_stb;
  logic                 bs_stb;
  logic [DIGITS*DW-1:0] seq_n;
  logic [DIGITS-1:0]    off_n;
  logic [CW-1:0]        count_n;
  logic                 match_n;

  assign ce_stb = ce & ~ce_d;
  assign bs_stb = bs & ~bs_d;

  // Entry takes priority; a simultaneous backspace is dropped, not deferred.
  always_comb begin
    seq_n   = disp_seq;
    off_n   = disp_off;
    count_n = count;
    match_n = 1'b0;
    if (ce_stb) begin
      seq_n   = {disp_seq[DIGITS*DW-DW-1:0], dat};
      off_n   = {disp_off[DIGITS-2:0], 1'b0};
      count_n = (count == CW'(DIGITS)) ? count : count + CW'(1);
      match_n = (count_n >= CW'(PAT_LEN)) && (seq_n[PAT_LEN*DW-1:0] == PATTERN);
    end else if (bs_stb && (count != '0)) begin
      seq_n   = {{DW{1'b0}}, disp_seq[DIGITS*DW-1:DW]};
      off_n   = {1'b1, disp_off[DIGITS-1:1]};
      count_n = count - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_d      <= 1'b0;
      bs_d      <= 1'b0;
      disp_seq  <= '0;
      disp_off  <= '1;
      count     <= '0;
      full      <= 1'b0;
      match     <= 1'b0;
      match_cnt <= 8'd0;
    end else begin
      ce_d     <= ce;
      bs_d     <= bs;
      disp_seq <= seq_n;
      disp_off <= off_n;
      count    <= count_n;
      full     <= (count_n == CW'(DIGITS));
      match    <= match_n;
      if (match_n && (match_cnt != 8'hFF)) begin
        match_cnt <= match_cnt + 8'd1;
      end
    end
  end

endmodule
